// File: rtl/sram_track_streamer_if.sv
// Command, stream and SRAM control signals of the track-buffer streamer.
// The bidirectional SRAM data bus stays a plain inout on the module.
interface sram_track_streamer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 14
) ();
    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic              sram_cs;
    logic              sram_oe;

    modport master (
        input  start, dir, base_addr, length, rd_ready, wr_data, wr_valid,
        output busy, done, rd_data, rd_valid, wr_ready,
               sram_addr, sram_we, sram_cs, sram_oe
    );

    modport slave (
        output start, dir, base_addr, length, rd_ready, wr_data, wr_valid,
        input  busy, done, rd_data, rd_valid, wr_ready,
               sram_addr, sram_we, sram_cs, sram_oe
    );
endinterface

// File: rtl/sram_track_streamer.sv
// Track-buffer SRAM initiator: turns a start/length command into sequential
// byte reads (to the rd stream) or writes (from the wr stream) with
// wrap-around addressing, and owns turnaround of the shared data bus.
module sram_track_streamer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_track_streamer_if.master bus,
    inout  wire [DATA_W-1:0]      sram_data
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] TURN = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              busy_q, done_q, wr_ready_q;
    logic              cs_q, oe_q, we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pend;            // memory is presenting read data this cycle
    logic [DATA_W-1:0] fifo0, fifo1;
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic       load_out, rd_room, rd_drained, wr_fire;
    logic [2:0] occ;

    // Read-side flow control: the output register plus the 2-entry FIFO give
    // three landing slots, so a read may issue only while every byte already
    // in flight or stored (minus the one popping now) leaves one slot free.
    always_comb begin
        load_out   = ~rd_valid_q | bus.rd_ready;
        occ        = 3'(cs_q & ~we_q) + 3'(pend) + 3'(fifo_cnt)
                   + 3'(rd_valid_q & ~bus.rd_ready);
        rd_room    = occ < 3'd3;
        rd_drained = (remaining == '0) && !cs_q && !pend && (fifo_cnt == '0)
                   && (!rd_valid_q || bus.rd_ready);
        wr_fire    = bus.wr_valid & wr_ready_q;
    end

    // Command sequencing and registered SRAM control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            cs_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            pend        <= 1'b0;
        end else begin
            pend <= cs_q & oe_q & ~we_q;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.length == '0) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else if (!bus.dir) begin
                            // first read issues on the accepting edge
                            state       <= RD;
                            cs_q        <= 1'b1;
                            oe_q        <= 1'b1;
                            sram_addr_q <= bus.base_addr;
                            addr        <= bus.base_addr + 1'b1;
                            remaining   <= bus.length - 1'b1;
                        end else begin
                            state      <= WR;
                            addr       <= bus.base_addr;
                            remaining  <= bus.length;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if ((remaining != '0) && rd_room) begin
                        cs_q        <= 1'b1;
                        oe_q        <= 1'b1;
                        sram_addr_q <= addr;
                        addr        <= addr + 1'b1;
                        remaining   <= remaining - 1'b1;
                    end else begin
                        cs_q <= 1'b0;
                        oe_q <= 1'b0;
                        if (rd_drained) state <= TURN;
                    end
                end
                WR: begin
                    if (wr_fire) begin
                        cs_q        <= 1'b1;
                        oe_q        <= 1'b1;
                        we_q        <= 1'b1;
                        sram_addr_q <= addr;
                        wdata_q     <= bus.wr_data;
                        addr        <= addr + 1'b1;
                        remaining   <= remaining - 1'b1;
                        wr_ready_q  <= (remaining != LEN_W'(1));
                    end else begin
                        cs_q <= 1'b0;
                        oe_q <= 1'b0;
                        we_q <= 1'b0;
                        if (remaining == '0) state <= TURN;
                    end
                end
                TURN: begin
                    state  <= FIN;
                    done_q <= 1'b1;
                end
                FIN: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Captured read bytes: output register fed by a 2-entry FIFO, with a
    // direct path into the output register when the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo0      <= '0;
            fifo1      <= '0;
            fifo_cnt   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (load_out) begin
            if (fifo_cnt != '0) begin
                rd_data_q  <= fifo0;
                rd_valid_q <= 1'b1;
                if (pend) begin
                    if (fifo_cnt == 2'd1) begin
                        fifo0 <= sram_data;
                    end else begin
                        fifo0 <= fifo1;
                        fifo1 <= sram_data;
                    end
                end else begin
                    fifo0    <= fifo1;
                    fifo_cnt <= fifo_cnt - 1'b1;
                end
            end else if (pend) begin
                rd_data_q  <= sram_data;
                rd_valid_q <= 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end else if (pend) begin
            if (fifo_cnt == '0) fifo0 <= sram_data;
            else                fifo1 <= sram_data;
            fifo_cnt <= fifo_cnt + 1'b1;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_we   = we_q;
    assign bus.sram_cs   = cs_q;
    assign bus.sram_oe   = oe_q;
    assign sram_data     = we_q ? wdata_q : 'z;
endmodule

// File: tb/tb_sram_track_streamer.sv
// Bench for sram_track_streamer: behavioural SRAM, shadow memory model of the
// track buffer, randomized stream handshakes and bus-ownership monitors.
module tb_sram_track_streamer;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 14;
    localparam int DEPTH  = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_track_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
    wire [DATA_W-1:0] sram_data;

    sram_track_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sram_data(sram_data)
    );

    // Behavioural synchronous SRAM.
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] mem_q = '0;
    logic       mem_drive = 1'b0;
    assign sram_data = mem_drive ? mem_q : 'z;
    always @(posedge clk) begin
        if (bus.sram_cs && bus.sram_oe && bus.sram_we) mem[bus.sram_addr] <= sram_data;
        if (bus.sram_cs && bus.sram_oe && !bus.sram_we) mem_q <= mem[bus.sram_addr];
        mem_drive <= bus.sram_cs && bus.sram_oe && !bus.sram_we;
    end

    logic [7:0] mdl [0:DEPTH-1];
    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc++;

    // Bus ownership monitors.
    int conflicts = 0, turn_viol = 0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (mem_drive && bus.sram_we) conflicts++;
        if (bus.sram_cs && !bus.sram_we && prev_wr) turn_viol++;
        prev_wr = bus.sram_cs && bus.sram_we;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] wbytes [$];
    logic [7:0] pops [$];
    int pop_cyc [$];
    int wa_q [$], wd_q [$], wc_q [$];
    int done_cnt, done_cyc, cs_cnt, start_cyc;

    // Issue one command (called at a negedge) and service its stream until
    // done has pulsed and busy has dropped, or the cycle budget runs out.
    task automatic run_cmd(input logic d, input int base, input int len,
                           input int rmode, input int vmode);
        int taken = 0;
        int budget = 4 * len + 40;
        logic finished = 1'b0;
        pops.delete(); pop_cyc.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0; cs_cnt = 0; done_cyc = 0;
        bus.start = 1'b1; bus.dir = d;
        bus.base_addr = ADDR_W'(base); bus.length = LEN_W'(len);
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (done_cnt > 0 && !bus.busy) begin finished = 1'b1; break; end
            if (bus.sram_cs) cs_cnt++;
            if (bus.sram_cs && bus.sram_oe && bus.sram_we) begin
                wa_q.push_back(int'(bus.sram_addr)); wd_q.push_back(int'(sram_data));
                wc_q.push_back(cyc);
            end
            case (rmode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = (n % 3 == 0);
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            bus.wr_valid = d && (taken < len) && (vmode == 0 || $urandom_range(0, 3) != 0);
            bus.wr_data  = (taken < len) ? wbytes[taken] : 8'($urandom);
            if (bus.rd_valid && bus.rd_ready) begin
                pops.push_back(bus.rd_data); pop_cyc.push_back(cyc);
            end
            if (bus.wr_valid && bus.wr_ready) taken++;
            @(negedge clk);
        end
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        check_eq("cmd_complete", 32'(finished), 1);
        check_eq("done_once", done_cnt, 1);
    endtask

    task automatic fill_random(input int len);
        wbytes.delete();
        for (int i = 0; i < len; i++) wbytes.push_back(8'($urandom));
    endtask

    task automatic verify_write(input string tag, input int base, input int len);
        int bad = 0;
        check_eq({tag, "_wr_count"}, wa_q.size(), len);
        for (int i = 0; i < len; i++) begin
            int a = (base + i) % DEPTH;
            mdl[a] = wbytes[i];
            if (i < wa_q.size())
                if (wa_q[i] != a || wd_q[i] != int'(wbytes[i])) bad++;
        end
        check_eq({tag, "_wr_addr_data"}, bad, 0);
    endtask

    task automatic verify_read(input string tag, input int base, input int len);
        int bad = 0;
        check_eq({tag, "_rd_count"}, pops.size(), len);
        for (int i = 0; i < len && i < pops.size(); i++)
            if (pops[i] !== mdl[(base + i) % DEPTH]) bad++;
        check_eq({tag, "_rd_data"}, bad, 0);
    endtask

    initial begin
        int base, len, got, stray, bad;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; mdl[i] = '0; end
        bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.rd_ready = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_rd_valid", bus.rd_valid, 0);
        check_eq("rst_rd_data", bus.rd_data, 0);
        check_eq("rst_wr_ready", bus.wr_ready, 0);
        check_eq("rst_cs", bus.sram_cs, 0);
        check_eq("rst_oe", bus.sram_oe, 0);
        check_eq("rst_we", bus.sram_we, 0);
        check_eq("rst_addr", bus.sram_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: four-byte write, wr_valid held high
        wbytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_cmd(1'b1, 'h10, 4, 0, 0);
        verify_write("t1", 'h10, 4);
        if (wc_q.size() == 4) check_eq("t1_consecutive", wc_q[3] - wc_q[0], 3);
        check_eq("t1_turnaround_gap", done_cyc - wc_q[$], 2);
        check_eq("t1_busy_after", bus.busy, 0);
        check_eq("t1_mem", {mem['h10], mem['h11], mem['h12], mem['h13]}, 32'hA1A2A3A4);

        // 2: read back with rd_ready high
        run_cmd(1'b0, 'h10, 4, 0, 0);
        verify_read("t2", 'h10, 4);
        if (pop_cyc.size() == 4) begin
            check_eq("t2_first_latency", pop_cyc[0] - start_cyc, 3);
            check_eq("t2_consecutive", pop_cyc[3] - pop_cyc[0], 3);
            check_eq("t2_done_gap", done_cyc - pop_cyc[3], 2);
        end

        // full-buffer write from a random base with a gappy source
        base = $urandom_range(0, DEPTH - 1);
        fill_random(DEPTH);
        run_cmd(1'b1, base, DEPTH, 0, 2);
        verify_write("full", base, DEPTH);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== mdl[i]) bad++;
        check_eq("full_mem_image", bad, 0);

        // 3: 16-byte read with rd_ready pattern 1,0,0
        base = $urandom_range(0, DEPTH - 1);
        run_cmd(1'b0, base, 16, 1, 0);
        verify_read("t3", base, 16);

        // randomized mix of short reads and writes
        for (int k = 0; k < 8; k++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 40);
            if (k % 2 == 0) begin
                fill_random(len);
                run_cmd(1'b1, base, len, 0, 2);
                verify_write("rnd", base, len);
            end else begin
                run_cmd(1'b0, base, len, 2, 0);
                verify_read("rnd", base, len);
            end
        end

        // 4: wrap-around write, then zero-length commands
        fill_random(3);
        run_cmd(1'b1, 'h1FFE, 3, 0, 0);
        verify_write("t4", 'h1FFE, 3);
        run_cmd(1'b0, 'h1FFE, 3, 2, 0);
        verify_read("t4", 'h1FFE, 3);
        run_cmd(1'b0, 'h0100, 0, 0, 0);
        check_eq("t4_len0_done_cycle", done_cyc - start_cyc, 1);
        check_eq("t4_len0_no_cs", cs_cnt, 0);
        run_cmd(1'b1, 'h0100, 0, 0, 0);
        check_eq("t4_len0w_no_cs", cs_cnt, 0);

        // 5: write then read back-to-back
        fill_random(2);
        run_cmd(1'b1, 'h0200, 2, 0, 0);
        verify_write("t5", 'h0200, 2);
        run_cmd(1'b0, 'h0200, 2, 0, 0);
        verify_read("t5", 'h0200, 2);

        // 6: reset in the middle of a read
        base = 'h0400;
        bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = ADDR_W'(base);
        bus.length = LEN_W'(10); bus.rd_ready = 1'b1;
        pops.delete();
        @(negedge clk);
        bus.start = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && got < 2; n++) begin
            if (bus.rd_valid) begin pops.push_back(bus.rd_data); got++; end
            @(negedge clk);
        end
        check_eq("t6_two_popped", got, 2);
        if (got == 2) begin
            check_eq("t6_pop0", pops[0], mdl[base]);
            check_eq("t6_pop1", pops[1], mdl[base + 1]);
        end
        rst = 1'b1; bus.rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_cs", bus.sram_cs, 0);
        check_eq("t6_oe", bus.sram_oe, 0);
        check_eq("t6_we_drive", bus.sram_we, 0);
        check_eq("t6_rd_valid", bus.rd_valid, 0);
        check_eq("t6_busy", bus.busy, 0);
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            if (bus.done || bus.sram_cs) stray++;
            @(negedge clk);
        end
        check_eq("t6_quiet_after_reset", stray, 0);
        run_cmd(1'b0, base, 5, 2, 0);
        verify_read("t6_after", base, 5);

        check_eq("bus_conflicts", conflicts, 0);
        check_eq("turnaround_violations", turn_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
